pc_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly downstream of the next-address logic.
- Holds the architectural PC and drives it back upstream; upstream returns next_addr_i, either pc+4 or a branch/jump target.
- Runs the request/ack handshake to instruction memory, tolerates variable memory latency, and loads the IF/ID pipeline register.
- Honours stall from the hazard unit and flush (redirect) from the branch unit.

---
 rtl/pc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, runs the req/ack handshake
// to instruction memory and loads the IF/ID pipeline register.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] next_addr_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              inst_ack_i,
  input  logic [ADDR_W-1:0] inst_data_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [ADDR_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_KILL = 2'd3;

  logic [1:0]        state;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [ADDR_W-1:0] buf_inst;

  // NOTE: all state uses non-blocking assignments so every branch reads the
  // pre-edge values (e.g. id_pc_o takes the old inst_addr_o while it updates).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc_o        <= RESET_PC;
      inst_addr_o <= RESET_PC;
      inst_req_o  <= 1'b0;
      id_pc_o     <= '0;
      id_inst_o   <= NOP_INST;
      id_valid_o  <= 1'b0;
      // NOTE: only the valid flag is reset; the buffered data is never read
      // while buf_valid is low, so it needs no reset.
      buf_valid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          inst_req_o <= 1'b1;
          state      <= ST_REQ;
          if (flush_i) begin
            pc_o        <= next_addr_i;
            inst_addr_o <= next_addr_i;
            id_valid_o  <= 1'b0;
            id_inst_o   <= NOP_INST;
          end else begin
            inst_addr_o <= pc_o;
          end
        end

        ST_REQ: begin
          if (flush_i) begin
            id_valid_o <= 1'b0;
            id_inst_o  <= NOP_INST;
            pc_o       <= next_addr_i;
            // An unacked request cannot be withdrawn; wait it out in KILL.
            if (inst_ack_i) inst_addr_o <= next_addr_i;
            else            state       <= ST_KILL;
          end else if (inst_ack_i) begin
            if (stall_i) begin
              buf_valid  <= 1'b1;
              buf_pc     <= inst_addr_o;
              buf_inst   <= inst_data_i;
              inst_req_o <= 1'b0;
              state      <= ST_HOLD;
            end else begin
              id_valid_o  <= 1'b1;
              id_pc_o     <= inst_addr_o;
              id_inst_o   <= inst_data_i;
              pc_o        <= next_addr_i;
              inst_addr_o <= next_addr_i;
            end
          end else if (!stall_i) begin
            id_valid_o <= 1'b0;
            id_inst_o  <= NOP_INST;
          end
        end

        ST_HOLD: begin
          if (flush_i) begin
            buf_valid   <= 1'b0;
            id_valid_o  <= 1'b0;
            id_inst_o   <= NOP_INST;
            pc_o        <= next_addr_i;
            inst_addr_o <= next_addr_i;
            inst_req_o  <= 1'b1;
            state       <= ST_REQ;
          end else if (!stall_i) begin
            buf_valid   <= 1'b0;
            id_valid_o  <= buf_valid;
            id_pc_o     <= buf_pc;
            id_inst_o   <= buf_inst;
            pc_o        <= next_addr_i;
            inst_addr_o <= next_addr_i;
            inst_req_o  <= 1'b1;
            state       <= ST_REQ;
          end
        end

        ST_KILL: begin
          id_valid_o <= 1'b0;
          id_inst_o  <= NOP_INST;
          if (flush_i) pc_o <= next_addr_i;
          // Stale data is dropped; refetch from the newest redirect target.
          if (inst_ack_i) begin
            inst_addr_o <= flush_i ? next_addr_i : pc_o;
            state       <= ST_REQ;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random stall/flush/ack traffic,
// all outputs compared each cycle against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_addr_i;
  logic        stall_i;
  logic        flush_i;
  logic        inst_ack_i;
  logic [31:0] inst_data_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic [31:0] pc_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .next_addr_i(next_addr_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .inst_ack_i (inst_ack_i),
    .inst_data_i(inst_data_i),
    .inst_req_o (inst_req_o),
    .inst_addr_o(inst_addr_o),
    .pc_o       (pc_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_valid_o (id_valid_o)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Model: PC, outstanding fetch, whether that fetch is doomed by a redirect,
  // an instruction parked because ID stalled, and the IF/ID contents.
  logic [31:0] m_pc, m_addr, m_id_pc, m_id_inst, m_held_pc, m_held_inst;
  bit          m_req, m_started, m_dead, m_held, m_id_valid;

  task automatic m_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_req = 0; m_started = 0; m_dead = 0;
    m_held = 0; m_id_valid = 0; m_id_pc = 32'h0; m_id_inst = NOP;
  endtask

  task automatic m_bubble();
    m_id_valid = 0; m_id_inst = NOP;
  endtask

  task automatic m_step(input bit r, input bit st, input bit fl,
                        input logic [31:0] nxt, input bit ack);
    if (r) begin
      m_reset();
    end else if (!m_started) begin
      m_started = 1; m_req = 1;
      if (fl) begin m_pc = nxt; m_bubble(); end
      m_addr = m_pc;
    end else if (m_held) begin
      if (fl) begin
        m_held = 0; m_bubble();
        m_pc = nxt; m_addr = nxt; m_req = 1;
      end else if (!st) begin
        m_id_valid = 1; m_id_pc = m_held_pc; m_id_inst = m_held_inst;
        m_held = 0; m_pc = nxt; m_addr = nxt; m_req = 1;
      end
    end else if (m_dead) begin
      m_bubble();
      if (fl) m_pc = nxt;
      if (ack) begin m_dead = 0; m_addr = m_pc; end
    end else if (fl) begin
      m_bubble(); m_pc = nxt;
      if (ack) m_addr = nxt; else m_dead = 1;
    end else if (ack) begin
      if (st) begin
        m_held = 1; m_held_pc = m_addr; m_held_inst = mem(m_addr); m_req = 0;
      end else begin
        m_id_valid = 1; m_id_pc = m_addr; m_id_inst = mem(m_addr);
        m_pc = nxt; m_addr = nxt;
      end
    end else if (!st) begin
      m_bubble();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("inst_req", {31'b0, inst_req_o}, {31'b0, m_req});
    chk("inst_addr", inst_addr_o, m_addr);
    chk("pc", pc_o, m_pc);
    chk("id_valid", {31'b0, id_valid_o}, {31'b0, m_id_valid});
    chk("id_inst", id_inst_o, m_id_inst);
    if (m_id_valid) chk("id_pc", id_pc_o, m_id_pc);
  endtask

  // One clock: compare at the falling edge, drive inputs, advance model, wait.
  task automatic cyc(input bit r, input bit st, input bit fl,
                     input logic [31:0] tgt, input bit ack);
    logic [31:0] nxt;
    chk_all();
    nxt         = fl ? tgt : m_pc + 32'd4;
    rst         = r;
    stall_i     = st;
    flush_i     = fl;
    next_addr_i = nxt;
    inst_ack_i  = ack;
    inst_data_i = ack ? mem(inst_addr_o) : $urandom;
    m_step(r, st, fl, nxt, ack && m_req);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; stall_i = 0; flush_i = 0; inst_ack_i = 0;
    next_addr_i = 0; inst_data_i = 0;
    m_reset();
    repeat (2) @(negedge clk);

    // Zero-wait streaming from reset.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("first_req", {31'b0, inst_req_o}, 32'd1);
    chk("first_addr", inst_addr_o, 32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("stream0_pc", id_pc_o, 32'h0);
    chk("stream0_inst", id_inst_o, mem(32'h0));
    cyc(0, 0, 0, 0, 1);
    chk("stream1_pc", id_pc_o, 32'h4);
    cyc(0, 0, 0, 0, 1);
    chk("stream2_pc", id_pc_o, 32'h8);
    chk("stream2_valid", {31'b0, id_valid_o}, 32'd1);

    // Two wait states on 0x4, then stall at 0x8, then redirect during 0x10.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("wait_addr", inst_addr_o, 32'h4);
    chk("wait_valid", {31'b0, id_valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("wait_done_id", id_pc_o, 32'h4);
    chk("wait_done_pc", pc_o, 32'h8);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    chk("stall_req", {31'b0, inst_req_o}, 32'd0);
    chk("stall_id", id_pc_o, 32'h4);
    cyc(0, 0, 0, 0, 0);
    chk("unstall_id", id_pc_o, 32'h8);
    chk("unstall_addr", inst_addr_o, 32'hC);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h100, 0);
    chk("kill_addr", inst_addr_o, 32'h10);
    chk("kill_pc", pc_o, 32'h100);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("redir_addr", inst_addr_o, 32'h100);
    chk("redir_valid", {31'b0, id_valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("redir_id", id_pc_o, 32'h100);

    // Flush and stall together while holding a buffered instruction.
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 32'h200, 0);
    chk("hold_flush_addr", inst_addr_o, 32'h200);
    chk("hold_flush_req", {31'b0, inst_req_o}, 32'd1);
    chk("hold_flush_valid", {31'b0, id_valid_o}, 32'd0);

    // Reset in the middle of a request at 0x40, then a late ack.
    cyc(0, 0, 1, 32'h40, 1);
    cyc(0, 0, 0, 0, 0);
    chk("mid_addr", inst_addr_o, 32'h40);
    cyc(1, 0, 0, 0, 0);
    chk("rst_req", {31'b0, inst_req_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", id_inst_o, NOP);
    cyc(0, 0, 0, 0, 1);
    chk("late_ack_valid", {31'b0, id_valid_o}, 32'd0);
    chk("restart_addr", inst_addr_o, 32'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 10,
          $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 1) == 1);
    end
    chk_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
